// File: rtl/alu_accum_seq.sv
// alu_accum_seq: sequencing front-end for the combinational ALU.
// Folds a packet of operand beats into an accumulator by driving the ALU
// and capturing its answer, then presents the reduced result, beat count
// and saturation flag on an output valid/ready stream.
module alu_accum_seq #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_op,
   input  logic             in_last,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [1:0]       alu_op,
   input  logic [WIDTH-1:0] alu_ans,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CNT_W-1:0] out_count,
   output logic             out_sat
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t           state, state_nxt;
   logic [WIDTH-1:0] acc, acc_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             sat, sat_nxt;
   logic             accept;

   // Saturating beat-count increment; pins at the all-ones value.
   function automatic logic [CNT_W-1:0] cnt_inc_sat(input logic [CNT_W-1:0] c);
      return (c == CNT_MAX) ? c : c + 1'b1;
   endfunction

   // ALU operands follow the accumulator and the incoming beat directly.
   assign alu_a    = acc;
   assign alu_b    = in_data;
   assign alu_op   = in_op;
   assign in_ready = (state != DONE);
   assign accept   = in_valid & in_ready;

   // Next-state and accumulator update logic.
   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      cnt_nxt   = cnt;
      sat_nxt   = sat;
      case (state)
         IDLE: begin
            if (accept) begin
               acc_nxt   = in_data;
               cnt_nxt   = {{(CNT_W-1){1'b0}}, 1'b1};
               sat_nxt   = 1'b0;
               state_nxt = in_last ? DONE : ACCUM;
            end
         end
         ACCUM: begin
            if (accept) begin
               acc_nxt = alu_ans;
               cnt_nxt = cnt_inc_sat(cnt);
               if (cnt == CNT_MAX) sat_nxt = 1'b1;
               if (in_last) state_nxt = DONE;
            end
         end
         DONE: begin
            if (out_valid && out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, accumulator and registered result outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         acc       <= '0;
         cnt       <= '0;
         sat       <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_count <= '0;
         out_sat   <= 1'b0;
      end else begin
         state <= state_nxt;
         acc   <= acc_nxt;
         cnt   <= cnt_nxt;
         sat   <= sat_nxt;
         if (state != DONE && state_nxt == DONE) begin
            out_valid <= 1'b1;
            out_data  <= acc_nxt;
            out_count <= cnt_nxt;
            out_sat   <= sat_nxt;
         end else if (state == DONE && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
